// File: rtl/output_formatter_if.sv
`default_nettype none
// ============================================================================
// Interface : output_formatter_if
// Brief     : Valid/ready byte link from the output formatter to the host.
//             master = formatter side (drives data/valid), slave = host side.
// Revision  : 1.0  initial release
// ============================================================================
interface output_formatter_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface
`default_nettype wire

// File: rtl/output_formatter.sv
`default_nettype none
// ============================================================================
// Module    : output_formatter
// Brief     : Buffers 3-bit execute output values in a FIFO and sends them to
//             the host as ASCII digits separated by ',', terminated by '\n'
//             once the CPU has halted and the FIFO has drained.
// Options   : OUTFMT_STALL_EN - when defined, stall flags FIFO count >= DEPTH-1;
//             otherwise stall is tied low.
// Revision  : 1.0  initial release
// ============================================================================
module output_formatter #(
  parameter int DEPTH = 8
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  input  wire logic [2:0] reg_out,
  input  wire logic       out_valid,
  input  wire logic       halt,
  output_formatter_if.master tx,
  output logic            overflow,
  output logic            done,
  output logic            stall
);

  localparam int              c_PW    = $clog2(DEPTH);
  localparam int              c_CW    = c_PW + 1;
  localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COMMA   = 3'd1,
    S_DIGIT   = 3'd2,
    S_NEWLINE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [7:0]      r_tx_data;
  logic [7:0]      w_tx_data_nxt;
  logic            r_tx_valid;
  logic            w_tx_valid_nxt;
  logic [2:0]      r_mem [DEPTH];
  logic [c_PW-1:0] r_wr_ptr;
  logic [c_PW-1:0] r_rd_ptr;
  logic [c_CW-1:0] r_count;
  logic            r_first;
  logic            r_halt_seen;
  logic            r_overflow;

  logic            w_hs;
  logic            w_pop;
  logic            w_push_req;
  logic            w_push;
  logic [7:0]      w_digit;

  // A digit leaves the FIFO only when the host takes it; a push may use the
  // slot freed by a pop in the same cycle, so a full FIFO still accepts then.
  assign w_hs       = r_tx_valid && tx.tx_ready;
  assign w_pop      = (r_state == S_DIGIT) && w_hs;
  assign w_push_req = out_valid && (r_state != S_DONE);
  assign w_push     = w_push_req && ((r_count != c_DEPTH) || w_pop);
  assign w_digit    = 8'h30 + {5'b0, r_mem[r_rd_ptr]};

  assign tx.tx_data  = r_tx_data;
  assign tx.tx_valid = r_tx_valid;
  assign overflow    = r_overflow;
  assign done        = (r_state == S_DONE);

`ifdef OUTFMT_STALL_EN
  localparam logic [c_CW-1:0] c_STALL_LVL = c_CW'(DEPTH - 1);
  assign stall = (r_count >= c_STALL_LVL);
`else
  assign stall = 1'b0;
`endif

  // FIFO storage; contents are don't-care while the entry is not counted.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= reg_out;
    end
  end

  // FIFO pointers/count, stream flags and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_first     <= 1'b1;
      r_halt_seen <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PW'(1);
        r_first  <= 1'b0;
      end
      r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop);
      if (halt) begin
        r_halt_seen <= 1'b1;
      end
      if (w_push_req && !w_push) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // State and registered byte-link outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_valid <= w_tx_valid_nxt;
    end
  end

  // Next state and next byte; a presented byte holds until the handshake.
  always_comb begin
    w_state_nxt    = r_state;
    w_tx_data_nxt  = r_tx_data;
    w_tx_valid_nxt = r_tx_valid;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_tx_valid_nxt = 1'b1;
          if (r_first) begin
            w_state_nxt   = S_DIGIT;
            w_tx_data_nxt = w_digit;
          end else begin
            w_state_nxt   = S_COMMA;
            w_tx_data_nxt = 8'h2C;
          end
        end else if (r_halt_seen) begin
          w_state_nxt    = S_NEWLINE;
          w_tx_data_nxt  = 8'h0A;
          w_tx_valid_nxt = 1'b1;
        end
      end
      S_COMMA: begin
        if (w_hs) begin
          w_state_nxt   = S_DIGIT;
          w_tx_data_nxt = w_digit;
        end
      end
      S_DIGIT: begin
        if (w_hs) begin
          w_state_nxt    = S_IDLE;
          w_tx_valid_nxt = 1'b0;
        end
      end
      S_NEWLINE: begin
        if (w_hs) begin
          w_state_nxt    = S_DONE;
          w_tx_valid_nxt = 1'b0;
        end
      end
      S_DONE: begin
        w_tx_valid_nxt = 1'b0;
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_tx_valid_nxt = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire
